// File: rtl/uart_img_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_img_tx
//  Purpose  : Streams RGB565 frames as 8N1 UART bytes:
//             A5 5A, big-endian pixels, XOR checksum of the payload.
//  Revision : 1.0  initial release
// ============================================================================
module uart_img_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int H_DISP   = 640,
    parameter int V_DISP   = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int PIX_NUM  = H_DISP * V_DISP;
    localparam int CNT_W    = $clog2(PIX_NUM + 1);
    localparam int BAUD_W   = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0]  c_pix_num   = CNT_W'(PIX_NUM);
    localparam logic [7:0]        c_sync0     = 8'hA5;
    localparam logic [7:0]        c_sync1     = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR0     = 3'd1,
        S_HDR1     = 3'd2,
        S_PIX_WAIT = 3'd3,
        S_PIX_HI   = 3'd4,
        S_PIX_LO   = 3'd5,
        S_CSUM     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t             r_state;
    logic [15:0]        r_pix;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [7:0]         r_csum;
    logic               r_csum_sent;

    logic               r_active;
    logic [3:0]         r_bit_cnt;
    logic [BAUD_W-1:0]  r_baud_cnt;
    logic [8:0]         r_shift;

    logic               w_bit_end;
    logic               w_last;
    logic               w_can_load;
    logic               w_load;
    logic [7:0]         w_byte;

    // A new byte may enter on the final clock of the previous stop bit,
    // which keeps consecutive bytes gap-free on the wire.
    always_comb begin
        w_bit_end  = r_active && (r_baud_cnt == c_baud_last);
        w_last     = w_bit_end && (r_bit_cnt == 4'd9);
        w_can_load = !r_active || w_last;
        w_load     = 1'b0;
        w_byte     = 8'h00;
        case (r_state)
            S_HDR0: begin
                w_load = w_can_load;
                w_byte = c_sync0;
            end
            S_HDR1: begin
                w_load = w_can_load;
                w_byte = c_sync1;
            end
            S_PIX_HI: begin
                w_load = w_can_load;
                w_byte = r_pix[15:8];
            end
            S_PIX_LO: begin
                w_load = w_can_load;
                w_byte = r_pix[7:0];
            end
            S_CSUM: begin
                w_load = w_can_load && !r_csum_sent;
                w_byte = r_csum;
            end
            default: begin
                w_load = 1'b0;
                w_byte = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_shift    <= '1;
            tx         <= 1'b1;
        end else if (w_load) begin
            r_active   <= 1'b1;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_shift    <= {1'b1, w_byte};
            tx         <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_baud_cnt <= '0;
                if (r_bit_cnt == 4'd9) begin
                    r_active  <= 1'b0;
                    r_bit_cnt <= '0;
                    tx        <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    tx        <= r_shift[0];
                    r_shift   <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
            end
        end
    end

    // Pixel states advance when their byte is loaded, so the next pixel
    // can be accepted while the previous low byte is still shifting out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pix       <= '0;
            r_pix_cnt   <= '0;
            r_csum      <= '0;
            r_csum_sent <= 1'b0;
            pix_ready   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pix_cnt   <= '0;
                    r_csum      <= '0;
                    r_csum_sent <= 1'b0;
                    if (frame_start) begin
                        r_state <= S_HDR0;
                        busy    <= 1'b1;
                    end
                end
                S_HDR0: begin
                    if (w_load) r_state <= S_HDR1;
                end
                S_HDR1: begin
                    if (w_load) begin
                        r_state   <= S_PIX_WAIT;
                        pix_ready <= 1'b1;
                    end
                end
                S_PIX_WAIT: begin
                    if (pix_valid && pix_ready) begin
                        r_pix     <= pix_data;
                        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                        r_state   <= S_PIX_HI;
                        pix_ready <= 1'b0;
                    end
                end
                S_PIX_HI: begin
                    if (w_load) begin
                        r_csum  <= r_csum ^ w_byte;
                        r_state <= S_PIX_LO;
                    end
                end
                S_PIX_LO: begin
                    if (w_load) begin
                        r_csum <= r_csum ^ w_byte;
                        if (r_pix_cnt == c_pix_num) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state   <= S_PIX_WAIT;
                            pix_ready <= 1'b1;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_load) begin
                        r_csum_sent <= 1'b1;
                    end else if (r_csum_sent && w_last) begin
                        r_state    <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_img_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_img_tx
//  Purpose  : Directed self-checking bench for uart_img_tx with a UART decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_img_tx;

    localparam int B = 10;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        tx;
    logic        busy;
    logic        frame_done;

    logic        pix_en;
    logic        feed_clr;
    logic        tab_sel;
    logic [2:0]  pix_idx;
    logic [15:0] tab1 [4];
    logic [15:0] tab2 [4];
    logic [7:0]  exp1 [11];
    logic [7:0]  exp2 [11];

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          n_ferr = 0;

    logic [7:0]  q_bytes [$];
    int          q_start [$];
    logic        mon_busy = 1'b0;
    int          mon_cnt = 0;
    int          mon_t0 = 0;
    logic [7:0]  mon_sh = 8'h00;

    uart_img_tx #(
        .CLK_FREQ (1000),
        .UART_BPS (100),
        .H_DISP   (2),
        .V_DISP   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream pixel source: advances on every accepted handshake.
    always @(posedge clk) begin
        if (feed_clr) pix_idx <= 3'd0;
        else if (pix_valid && pix_ready) pix_idx <= pix_idx + 3'd1;
    end

    always_comb begin
        pix_valid = pix_en;
        pix_data  = tab_sel ? tab2[pix_idx[1:0]] : tab1[pix_idx[1:0]];
    end

    // UART decoder: samples at bit centres, counted in clocks from the start edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy <= 1'b0;
            mon_cnt  <= 0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy <= 1'b1;
                mon_cnt  <= 1;
                mon_t0   <= cyc;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % B) == 5)
                mon_sh[3'((mon_cnt - 15) / B)] <= tx;
            if (mon_cnt == 95) begin
                q_bytes.push_back(mon_sh);
                q_start.push_back(mon_t0);
                if (tx !== 1'b1) n_ferr <= n_ferr + 1;
                mon_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (frame_done === 1'b1) n_done <= n_done + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected end before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] byte_at(input int idx);
        if (idx < q_bytes.size()) return {24'd0, q_bytes[idx]};
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] start_at(input int idx);
        if (idx < q_start.size()) return q_start[idx];
        return 32'hDEAD;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_frame(output int n);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = cyc;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d);
        d = -1;
        for (int i = 0; i < budget; i++) begin
            if (frame_done === 1'b1) begin
                d = cyc;
                break;
            end
            tick();
        end
        check("done_seen", (d != -1), 1);
    endtask

    task automatic check_frame(input string tag, input int base, input logic sel);
        check({tag, "_nbytes"}, q_bytes.size() - base, 11);
        for (int k = 0; k < 11; k++)
            check($sformatf("%s_byte%0d", tag, k), byte_at(base + k),
                  {24'd0, sel ? exp2[k] : exp1[k]});
        check({tag, "_framing"}, n_ferr, 0);
    endtask

    int n, s, d, d0, n2, d2, base, base2, bad;

    initial begin
        exp1 = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
        exp2 = '{8'hA5, 8'h5A, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h80, 8'h01, 8'h7E, 8'h3C, 8'hC3};
        tab1 = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
        tab2 = '{16'h0F0F, 16'h0000, 16'h8001, 16'h7E3C};
        rst_n = 1'b0; frame_start = 1'b0; pix_en = 1'b0; feed_clr = 1'b1; tab_sel = 1'b0;

        // Reset and idle quiet period
        repeat (5) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_done", frame_done, 0);
        rst_n = 1'b1;
        feed_clr = 1'b0;
        tick();
        check("rel_tx", tx, 1);
        check("rel_busy", busy, 0);
        check("rel_ready", pix_ready, 0);
        bad = 0;
        d0 = n_done;
        for (int i = 0; i < 2000; i++) begin
            if (tx !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        check("idle_quiet", bad, 0);
        check("idle_nbytes", q_bytes.size(), 0);
        check("idle_ndone", n_done - d0, 0);

        // Full frame, pix_valid held high
        pix_en = 1'b1;
        base = q_bytes.size();
        start_frame(n);
        s = n + 1;
        wait_done(3000, d);
        check("ff_done_cyc", d, s + 1100);
        check("ff_busy_at_done", busy, 1);
        tick();
        check("ff_done_width", frame_done, 0);
        check("ff_busy_fall", busy, 0);
        check_frame("ff", base, 1'b0);
        check("ff_first_start", start_at(base), s);
        check("ff_last_start", start_at(base + 10), s + 1000);

        // Upstream stall of 500 clocks before the third pixel
        feed_clr = 1'b1; tick(); feed_clr = 1'b0;
        base = q_bytes.size();
        start_frame(n);
        s = n + 1;
        wait_until(s + 350);
        pix_en = 1'b0;
        wait_until(s + 599);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            if (tx !== 1'b1 || pix_ready !== 1'b1) bad++;
            if (i == 499) pix_en = 1'b1;
            tick();
        end
        check("stall_idle_line", bad, 0);
        wait_done(3000, d);
        check("stall_done_cyc", d, s + 1600);
        check_frame("stall", base, 1'b0);
        check("stall_byte5_start", start_at(base + 5), s + 500);
        check("stall_byte6_start", start_at(base + 6), s + 1100);
        tick();

        // frame_start during HDR1 and PIX_LO is ignored
        feed_clr = 1'b1; tick(); feed_clr = 1'b0;
        base = q_bytes.size();
        d0 = n_done;
        start_frame(n);
        s = n + 1;
        wait_until(s + 50);
        pulse_start();
        wait_until(s + 250);
        pulse_start();
        wait_done(3000, d);
        check("ign_done_cyc", d, s + 1100);
        repeat (300) tick();
        check_frame("ign", base, 1'b0);
        check("ign_ndone", n_done - d0, 1);
        check("ign_busy", busy, 0);

        // Reset in the middle of the fifth byte
        feed_clr = 1'b1; tick(); feed_clr = 1'b0;
        base = q_bytes.size();
        start_frame(n);
        s = n + 1;
        wait_until(s + 450);
        check("mid_tx_pre", tx, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        repeat (3) tick();
        check("mid_rst_ready", pix_ready, 0);
        check("mid_abort_nbytes", q_bytes.size() - base, 4);
        rst_n = 1'b1;
        feed_clr = 1'b1; tick(); feed_clr = 1'b0;
        tick();
        base = q_bytes.size();
        start_frame(n);
        s = n + 1;
        wait_done(3000, d);
        check("post_done_cyc", d, s + 1100);
        check_frame("post", base, 1'b0);
        check("post_first_start", start_at(base), s);
        tick();

        // Two frames back to back with independent checksums
        feed_clr = 1'b1; tick(); feed_clr = 1'b0;
        base = q_bytes.size();
        start_frame(n);
        s = n + 1;
        wait_done(3000, d);
        check("b2b1_done_cyc", d, s + 1100);
        tab_sel = 1'b1;
        feed_clr = 1'b1;
        tick();
        feed_clr = 1'b0;
        check("b2b_busy_low", busy, 0);
        check_frame("b2b1", base, 1'b0);
        base2 = q_bytes.size();
        start_frame(n2);
        wait_done(3000, d2);
        check("b2b2_done_cyc", d2, n2 + 1101);
        check("b2b2_first_start", start_at(base2), n2 + 1);
        check_frame("b2b2", base2, 1'b1);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
